// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for hazard_ctrl_unit: RV32 instruction fields, operand-using opcodes,
// forward-select and controller-state encodings.
package hazard_ctrl_unit_pkg;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } struc_inst;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EM = 2'd1,
        FWD_MW = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R || opcode == OP_S || opcode == OP_B);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_match.sv
// Forward select for one source operand. EM beats MW; a load in EM has no result yet,
// and x0 or an unused source never forwards.
module hazard_ctrl_unit_fwd_match
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              use_i,
    input  logic [REG_AW-1:0] rd_em_i,
    input  logic              wr_em_i,
    input  logic              ld_em_i,
    input  logic [REG_AW-1:0] rd_mw_i,
    input  logic              wr_mw_i,
    output fwd_sel_e          sel_o
);

    logic src_live;

    assign src_live = use_i && (rs_i != '0);

    always_comb begin
        sel_o = FWD_RF;
        if (src_live && wr_em_i && !ld_em_i && (rd_em_i == rs_i)) begin
            sel_o = FWD_EM;
        end else if (src_live && wr_mw_i && (rd_mw_i == rs_i)) begin
            sel_o = FWD_MW;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the FD/EM/MW RV32 pipeline: operand forwarding,
// multi-cycle load freeze, load-use bubbles, redirect flushes. Perf counters: HAZARD_PERF_EN.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int Width        = 32,
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [Width-1:0]  ir_FD,
    input  logic [Width-1:0]  ir_EM,
    input  logic [Width-1:0]  ir_MW,
    input  logic              reg_wrEM,
    input  logic              reg_wrMW,
    input  logic              dmem_rdEM,
    input  logic              br_taken,
    input  logic              is_mret,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_FD,
    output logic              stall_EM,
    output logic              bubble_EM,
    output logic              flush_FD,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output hz_state_e         state_o
);

    localparam int SEQ_MAX = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
    localparam int SEQ_W   = (SEQ_MAX > 2) ? $clog2(SEQ_MAX) : 1;
    localparam logic [SEQ_W-1:0] WAIT_INIT  = SEQ_W'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
    localparam logic [SEQ_W-1:0] FLUSH_INIT = SEQ_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    struc_inst         inst_fd, inst_em, inst_mw;
    logic [REG_AW-1:0] rs1_fd, rs2_fd, rd_em, rd_mw;
    logic              rs1_used, rs2_used;
    fwd_sel_e          sel_a, sel_b;
    logic              redirect, load_use;
    logic              unused_fields;

    hz_state_e         state_q, state_d;
    logic [SEQ_W-1:0]  cnt_q, cnt_d;
    logic              stall_fd_c, stall_em_c, bubble_em_c, flush_fd_c;

    assign inst_fd = struc_inst'(ir_FD[31:0]);
    assign inst_em = struc_inst'(ir_EM[31:0]);
    assign inst_mw = struc_inst'(ir_MW[31:0]);
    assign unused_fields = ^{ir_FD, ir_EM, ir_MW};

    assign rs1_fd   = REG_AW'(inst_fd.rs1);
    assign rs2_fd   = REG_AW'(inst_fd.rs2);
    assign rd_em    = REG_AW'(inst_em.rd);
    assign rd_mw    = REG_AW'(inst_mw.rd);
    assign rs1_used = uses_rs1(inst_fd.opcode);
    assign rs2_used = uses_rs2(inst_fd.opcode);

    hazard_ctrl_unit_fwd_match #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_i    (rs1_fd),
        .use_i   (rs1_used),
        .rd_em_i (rd_em),
        .wr_em_i (reg_wrEM),
        .ld_em_i (dmem_rdEM),
        .rd_mw_i (rd_mw),
        .wr_mw_i (reg_wrMW),
        .sel_o   (sel_a)
    );

    hazard_ctrl_unit_fwd_match #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_i    (rs2_fd),
        .use_i   (rs2_used),
        .rd_em_i (rd_em),
        .wr_em_i (reg_wrEM),
        .ld_em_i (dmem_rdEM),
        .rd_mw_i (rd_mw),
        .wr_mw_i (reg_wrMW),
        .sel_o   (sel_b)
    );

    assign redirect = br_taken || is_mret;
    assign load_use = dmem_rdEM && (rd_em != '0) &&
                      ((rs1_used && (rd_em == rs1_fd)) || (rs2_used && (rd_em == rs2_fd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The cycle a load enters EM also freezes, so the load spends LOAD_LAT cycles in EM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_fd_c  = 1'b0;
        stall_em_c  = 1'b0;
        bubble_em_c = 1'b0;
        flush_fd_c  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    flush_fd_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (dmem_rdEM && (LOAD_LAT > 1)) begin
                    stall_fd_c = 1'b1;
                    stall_em_c = 1'b1;
                    state_d    = MEM_WAIT;
                    cnt_d      = WAIT_INIT;
                end else if (load_use) begin
                    stall_fd_c  = 1'b1;
                    bubble_em_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                    if (load_use) begin
                        stall_fd_c  = 1'b1;
                        bubble_em_c = 1'b1;
                    end
                end else begin
                    stall_fd_c = 1'b1;
                    stall_em_c = 1'b1;
                    cnt_d      = cnt_q - SEQ_W'(1);
                end
            end
            FLUSH: begin
                flush_fd_c = 1'b1;
                if (redirect) begin
                    cnt_d = FLUSH_INIT;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - SEQ_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset silences every output at once, including the combinational forward selects.
    assign fwd_a     = {2{~rst}} & sel_a;
    assign fwd_b     = {2{~rst}} & sel_b;
    assign stall_FD  = stall_fd_c  & ~rst;
    assign stall_EM  = stall_em_c  & ~rst;
    assign bubble_EM = bubble_em_c & ~rst;
    assign flush_FD  = flush_fd_c  & ~rst;
    assign state_o   = state_q;

    a_no_redirect_in_wait: assert property (@(posedge clk) disable iff (rst)
        (state_q == MEM_WAIT) |-> !(br_taken || is_mret));

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_FD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_FD && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
